// File: rtl/delta_comp_pkg.sv
// Shared constants and slot helpers for the delta trace compressor/decompressor pair.
// Slot 0 occupies the most significant PRECISION bits of each lane word.
package delta_comp_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int DELTA_SLOTS = 4;
  localparam int PRECISION   = DATA_WIDTH / DELTA_SLOTS;
  localparam int SLOT_W      = $clog2(DELTA_SLOTS);

  localparam logic [PRECISION-1:0]  INV       = {1'b1, {(PRECISION-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] NODATA    = {DELTA_SLOTS{INV}};
  localparam int                    DELTA_MAX = (2 ** (PRECISION-1)) - 1;
  localparam int                    DELTA_MIN = -DELTA_MAX;

  typedef enum logic {
    DD_IDLE   = 1'b0,
    DD_EXPAND = 1'b1
  } dd_state_e;

  function automatic logic [PRECISION-1:0] slot_get(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [SLOT_W-1:0]     k);
    logic [DATA_WIDTH-1:0] sh;
    sh = word << (int'(k) * PRECISION);
    return sh[DATA_WIDTH-1 -: PRECISION];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_delta(input logic [PRECISION-1:0] d);
    return {{(DATA_WIDTH-PRECISION){d[PRECISION-1]}}, d};
  endfunction

endpackage

// File: rtl/delta_slot_extract.sv
// Per-lane slot select and sign extension: the pending slot of the held entry
// and slot 0 of the entry currently offered at the input.
import delta_comp_pkg::*;

module delta_slot_extract (
  input  logic [DATA_WIDTH-1:0] held_i,
  input  logic [SLOT_W-1:0]     slot_i,
  input  logic [DATA_WIDTH-1:0] fresh_i,
  output logic [DATA_WIDTH-1:0] held_delta_o,
  output logic [DATA_WIDTH-1:0] fresh_delta_o
);

  assign held_delta_o  = sext_delta(slot_get(held_i, slot_i));
  assign fresh_delta_o = sext_delta(slot_get(fresh_i, '0));

endmodule

// File: rtl/delta_decompressor.sv
// Rebuilds the N-lane vector stream from raw and delta-compressed trace entries.
// Optional DELTA_DECOMP_CHECK_EN: all-lane emptiness check with partial-INV error.
//
// state     | meaning
// DD_IDLE   | no expansion pending (a raw vector may still be on the output)
// DD_EXPAND | compressed entry held, slot_q is the slot currently on the output
import delta_comp_pkg::*;

module delta_decompressor #(
  parameter int N = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            restart,
  input  logic                            valid_in,
  output logic                            in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]    vector_in,
  input  logic                            v_in_comp,
  output logic                            valid_out,
  input  logic                            out_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
  output logic                            err
);

  localparam logic [DATA_WIDTH-1:0] INV_SEXT  = sext_delta(INV);
  localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(DELTA_SLOTS - 1);

  dd_state_e                      state_q;
  logic [SLOT_W-1:0]              slot_q;
  logic [N-1:0][DATA_WIDTH-1:0]   entry_q;
  // The base vector is always the last vector emitted, so one register serves both.
  logic [N-1:0][DATA_WIDTH-1:0]   base_q;
  logic                           base_valid_q;
  logic                           valid_q;
  logic                           err_q;

  logic [SLOT_W-1:0]              nxt_slot;
  logic [N-1:0][DATA_WIDTH-1:0]   held_delta;
  logic [N-1:0][DATA_WIDTH-1:0]   fresh_delta;
  logic [N-1:0][DATA_WIDTH-1:0]   held_vec;
  logic [N-1:0][DATA_WIDTH-1:0]   fresh_vec;
  logic                           held_empty;
  logic                           held_bad;
  logic                           fresh_empty;
  logic                           fresh_bad;
  logic                           more;
  logic                           tail_bad;
  logic                           hs;
  logic                           accept;

  assign nxt_slot = slot_q + 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    delta_slot_extract u_extract (
      .held_i        (entry_q[i]),
      .slot_i        (nxt_slot),
      .fresh_i       (vector_in[i]),
      .held_delta_o  (held_delta[i]),
      .fresh_delta_o (fresh_delta[i])
    );
    assign held_vec[i]  = base_q[i] - held_delta[i];
    assign fresh_vec[i] = base_q[i] - fresh_delta[i];
  end

`ifdef DELTA_DECOMP_CHECK_EN
  logic [N-1:0] held_inv;
  logic [N-1:0] fresh_inv;

  for (genvar i = 0; i < N; i++) begin : g_inv
    assign held_inv[i]  = (held_delta[i] == INV_SEXT);
    assign fresh_inv[i] = (fresh_delta[i] == INV_SEXT);
  end

  // A partially empty slot still terminates the entry, but is flagged.
  assign held_empty  = |held_inv;
  assign held_bad    = (|held_inv) && !(&held_inv);
  assign fresh_empty = |fresh_inv;
  assign fresh_bad   = (|fresh_inv) && !(&fresh_inv);
`else
  assign held_empty  = (held_delta[0] == INV_SEXT);
  assign held_bad    = 1'b0;
  assign fresh_empty = (fresh_delta[0] == INV_SEXT);
  assign fresh_bad   = 1'b0;
`endif

  assign more     = (state_q == DD_EXPAND) && (slot_q != LAST_SLOT) && !held_empty;
  assign tail_bad = (state_q == DD_EXPAND) && (slot_q != LAST_SLOT) && held_bad;
  assign hs       = valid_q && out_ready;
  assign in_ready = !restart && (((state_q == DD_IDLE) && !valid_q) || (hs && !more));
  assign accept   = valid_in && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DD_IDLE;
      slot_q       <= '0;
      entry_q      <= '0;
      base_q       <= '0;
      base_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else if (restart) begin
      state_q      <= DD_IDLE;
      slot_q       <= '0;
      base_q       <= '0;
      base_valid_q <= 1'b0;
      valid_q      <= 1'b0;
    end else if (hs && more) begin
      base_q <= held_vec;
      slot_q <= nxt_slot;
    end else begin
      if (hs) begin
        valid_q <= 1'b0;
        state_q <= DD_IDLE;
        if (tail_bad) err_q <= 1'b1;
      end
      if (accept) begin
        if (!v_in_comp) begin
          base_q       <= vector_in;
          base_valid_q <= 1'b1;
          valid_q      <= 1'b1;
          state_q      <= DD_IDLE;
        end else if (!base_valid_q) begin
          err_q <= 1'b1;
        end else begin
          if (fresh_bad) err_q <= 1'b1;
          if (!fresh_empty) begin
            base_q  <= fresh_vec;
            valid_q <= 1'b1;
            state_q <= DD_EXPAND;
            slot_q  <= '0;
            entry_q <= vector_in;
          end
        end
      end
    end
  end

  assign valid_out  = valid_q;
  assign vector_out = base_q;
  assign err        = err_q;

endmodule

// File: tb/tb_delta_decompressor.sv
// Bench for delta_decompressor: directed scenarios then random traffic against a queue-based model.
module tb_delta_decompressor;

  localparam int N  = 8;
  localparam int DW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t v;
    bit   e;
  } exp_t;

  logic clk = 1'b0;
  logic rst, restart, valid_in, in_ready, v_in_comp, valid_out, out_ready, err;
  vec_t vector_in, vector_out;

  always #5 clk = ~clk;

  delta_decompressor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .vector_in  (vector_in),
    .v_in_comp  (v_in_comp),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .vector_out (vector_out),
    .err        (err)
  );

  exp_t q[$];
  vec_t base_m;
  bit   bv_m;
  bit   err_m;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t splat(input logic [DW-1:0] x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t cword(input logic [7:0] s0, input logic [7:0] s1,
                                 input logic [7:0] s2, input logic [7:0] s3);
    return splat({s0, s1, s2, s3});
  endfunction

  // Expand one accepted entry into the list of vectors it must produce.
  task automatic model_accept(input vec_t v, input bit comp);
    logic [7:0] b [N];
    int   ninv;
    bit   empty, bad, have;
    vec_t pend;
    if (!comp) begin
      q.push_back('{v, 1'b0});
      base_m = v;
      bv_m   = 1'b1;
      return;
    end
    if (!bv_m) begin
      err_m = 1'b1;
      return;
    end
    have = 1'b0;
    bad  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ninv = 0;
      for (int i = 0; i < N; i++) begin
        b[i] = v[i][31-8*k -: 8];
        if (b[i] == 8'h80) ninv++;
      end
`ifdef DELTA_DECOMP_CHECK_EN
      empty = (ninv > 0);
      bad   = (ninv > 0) && (ninv < N);
`else
      empty = (b[0] == 8'h80);
`endif
      if (empty) break;
      for (int i = 0; i < N; i++) begin
        int d;
        d = $signed(b[i]);
        base_m[i] = base_m[i] - DW'(d);
      end
      if (have) q.push_back('{pend, 1'b0});
      pend = base_m;
      have = 1'b1;
    end
    if (have) q.push_back('{pend, bad});
    else if (bad) err_m = 1'b1;
  endtask

  task automatic cyc(input bit vi, input bit comp, input vec_t v, input bit ordy,
                     input bit rs, input bit rr);
    bit exp_rdy, exp_hs;
    @(negedge clk);
    valid_in  = vi;
    v_in_comp = comp;
    vector_in = v;
    out_ready = ordy;
    restart   = rs;
    rst       = rr;
    #1;
    exp_rdy = !rs && ((q.size() == 0) || (q.size() == 1 && ordy));
    exp_hs  = (q.size() != 0) && ordy;
    chk("valid_out", valid_out, q.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    if (q.size() != 0) chk("vector_out", vector_out, q[0].v);
    else chk("err", err, err_m);
    if (rr) begin
      q.delete();
      bv_m  = 1'b0;
      err_m = 1'b0;
    end else if (rs) begin
      q.delete();
      bv_m = 1'b0;
    end else begin
      if (exp_hs) begin
        if (q[0].e) err_m = 1'b1;
        void'(q.pop_front());
      end
      if (vi && exp_rdy) model_accept(v, comp);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  function automatic vec_t rand_comp();
    vec_t v;
    int   nslot;
    logic [7:0] bt;
    nslot = $urandom_range(0, 4);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        if (k < nslot) begin
          bt = 8'($urandom_range(0, 255));
          if (bt == 8'h80) bt = 8'h7F;
        end else begin
          bt = 8'h80;
        end
        v[i][31-8*k -: 8] = bt;
      end
    if (nslot < 4 && $urandom_range(0, 3) == 0) v[$urandom_range(0, N-1)][31-8*nslot -: 8] = 8'h11;
    if ($urandom_range(0, 9) == 0) v[0][31:24] = 8'h80;
    return v;
  endfunction

  initial begin
    vec_t w;
    rst = 1'b1; restart = 1'b0; valid_in = 1'b0; v_in_comp = 1'b0;
    vector_in = '0; out_ready = 1'b0;
    bv_m = 1'b0; err_m = 1'b0; base_m = '0;

    cyc(0, 0, '0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 1);
    idle(1, 1);
    chk("vout_after_rst", vector_out, '0);

    // raw then immediate drain
    cyc(1, 0, splat(32'd100), 1, 0, 0);
    idle(2, 1);
    // raw then compressed {01,FF,80,80} back to back
    cyc(1, 0, splat(32'd100), 1, 0, 0);
    cyc(1, 1, cword(8'h01, 8'hFF, 8'h80, 8'h80), 1, 0, 0);
    chk("t2_first", q[0].v, splat(32'd99));
    idle(3, 1);
    // stalled expansion {7F,81,05,02}
    cyc(1, 0, splat(32'd1000), 1, 0, 0);
    cyc(1, 1, cword(8'h7F, 8'h81, 8'h05, 8'h02), 1, 0, 0);
    chk("t3_count", q.size(), 4);
    chk("t3_last", q[3].v, splat(32'd993));
    idle(3, 0);
    idle(5, 1);
    // compressed with no base
    cyc(0, 0, '0, 1, 0, 1);
    cyc(1, 1, cword(8'h01, 8'h02, 8'h80, 8'h80), 1, 0, 0);
    idle(1, 1);
    chk("t4_err", err, 1'b1);
    cyc(1, 0, splat(32'd5), 1, 0, 0);
    idle(2, 1);
    // rst during second slot
    cyc(1, 0, splat(32'd10), 1, 0, 0);
    cyc(1, 1, cword(8'h01, 8'h01, 8'h01, 8'h01), 1, 0, 0);
    idle(1, 1);
    cyc(0, 0, '0, 1, 0, 1);
    idle(1, 1);
    cyc(1, 1, cword(8'h01, 8'h01, 8'h80, 8'h80), 1, 0, 0);
    idle(2, 1);
    // restart mid-expansion drops base
    cyc(1, 0, splat(32'd20), 1, 0, 0);
    cyc(1, 1, cword(8'h01, 8'h01, 8'h01, 8'h80), 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    idle(1, 1);
    chk("restart_vout", vector_out, '0);
    cyc(1, 1, cword(8'h01, 8'h80, 8'h80, 8'h80), 1, 0, 0);
    idle(2, 1);
`ifdef DELTA_DECOMP_CHECK_EN
    cyc(0, 0, '0, 1, 0, 1);
    cyc(1, 0, splat(32'd50), 1, 0, 0);
    w = cword(8'h01, 8'h02, 8'h03, 8'h04);
    w[0] = {8'h01, 8'h80, 8'h03, 8'h04};
    cyc(1, 1, w, 1, 0, 0);
    chk("t6_count", q.size(), 1);
    idle(3, 1);
    chk("t6_err", err, 1'b1);
`endif

    for (int c = 0; c < 3000; c++) begin
      bit comp;
      comp = ($urandom_range(0, 2) != 0);
      if (comp) w = rand_comp();
      else for (int i = 0; i < N; i++) w[i] = $urandom;
      cyc($urandom_range(0, 3) != 0, comp, w, $urandom_range(0, 3) != 0,
          $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end
    idle(6, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
